// File: rtl/frequency_analyzer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frequency_analyzer_pkg
// Description : Shared types and helpers for the multichannel frequency
//               analyzer: FSM state encoding, the value-not-set marker, the
//               count-to-Hz scale helper and the in-band comparison.
// Revision    : 1.0 - initial release
// ============================================================================
package frequency_analyzer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LATCH   = 2'd2
    } state_t;

    // A runtime target or deviation of zero means "use the default"
    localparam logic [31:0] VALUE_NOT_SET = 32'd0;

    // Hz represented by one counted edge within a gate window
    function automatic longint unsigned scale_factor(
        input longint unsigned clock_frequency,
        input longint unsigned window_cycles
    );
        return clock_frequency / window_cycles;
    endfunction

    // |freq - target| <= deviation, evaluated with a 33-bit signed difference
    // so that neither operand order can wrap
    function automatic logic within_band(
        input logic [31:0] freq,
        input logic [31:0] target,
        input logic [31:0] deviation
    );
        logic signed [32:0] diff;
        logic        [32:0] magnitude;
        diff      = $signed({1'b0, freq}) - $signed({1'b0, target});
        magnitude = diff[32] ? 33'(-diff) : 33'(diff);
        return magnitude <= {1'b0, deviation};
    endfunction

endpackage : frequency_analyzer_pkg
`default_nettype wire

// File: rtl/frequency_channel_counter.sv
`default_nettype none
// ============================================================================
// Module      : frequency_channel_counter
// Description : One analyzer channel: two-flop synchronizer, rising-edge
//               detector and saturating edge counter with an overflow flag
//               that records edges lost to saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module frequency_channel_counter #(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     sample_data,
    input  logic                     restart,
    input  logic                     count_enable,
    output logic [COUNTER_WIDTH-1:0] edge_count,
    output logic                     overflow
);

    logic r_sync_meta;
    logic r_sync;
    logic r_prev;
    logic w_rise;

    // Bring the asynchronous tone input into the clock domain and keep one
    // extra stage so a rising edge can be seen as a 0 -> 1 pair
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync_meta <= 1'b0;
            r_sync      <= 1'b0;
            r_prev      <= 1'b0;
        end else begin
            r_sync_meta <= sample_data;
            r_sync      <= r_sync_meta;
            r_prev      <= r_sync;
        end
    end

    assign w_rise = r_sync & ~r_prev;

    // Count rising edges during the gate; hold at all-ones and flag overflow
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            edge_count <= '0;
            overflow   <= 1'b0;
        end else if (restart) begin
            edge_count <= '0;
            overflow   <= 1'b0;
        end else if (count_enable && w_rise) begin
            if (&edge_count) begin
                overflow <= 1'b1;
            end else begin
                edge_count <= edge_count + 1'b1;
            end
        end
    end

endmodule : frequency_channel_counter
`default_nettype wire

// File: rtl/multichannel_frequency_analyzer.sv
`default_nettype none
// ============================================================================
// Module      : multichannel_frequency_analyzer
// Description : Measures the rising-edge rate of CHANNELS tone inputs over a
//               programmable gate window, scales counts to Hz and flags each
//               channel as in-band against its target +/- deviation.
// Revision    : 1.0 - initial release
// ============================================================================
module multichannel_frequency_analyzer
    import frequency_analyzer_pkg::*;
#(
    parameter int CHANNELS          = 2,
    parameter int CLOCK_FREQUENCY   = 50000000,
    parameter int WINDOW_CYCLES     = 50000000,
    parameter int DEFAULT_FREQUENCY = 10000,
    parameter int DEFAULT_DEVIATION = 20,
    parameter int COUNTER_WIDTH     = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              clear,
    input  logic                              start,
    input  logic                              continuous,
    input  logic [CHANNELS-1:0]               sample_data,
    input  logic [CHANNELS*32-1:0]            target,
    input  logic [CHANNELS*32-1:0]            deviation,
    output logic [CHANNELS*COUNTER_WIDTH-1:0] freq_value,
    output logic [CHANNELS-1:0]               in_band,
    output logic [CHANNELS-1:0]               overflow,
    output logic                              freq_valid,
    output logic                              busy
);

    localparam logic [63:0] SCALE        = 64'(scale_factor(64'(CLOCK_FREQUENCY), 64'(WINDOW_CYCLES)));
    localparam int          WINDOW_WIDTH = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WINDOW_WIDTH-1:0] WINDOW_LAST = WINDOW_WIDTH'(WINDOW_CYCLES - 1);

    // Elaboration-time sanity checks on the parameter set
    if ((CLOCK_FREQUENCY % WINDOW_CYCLES) != 0) begin : g_bad_window_ratio
        $error("CLOCK_FREQUENCY must be an exact multiple of WINDOW_CYCLES");
    end
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("CHANNELS must be in 1..16");
    end
    if (COUNTER_WIDTH < 1 || COUNTER_WIDTH > 32) begin : g_bad_width
        $error("COUNTER_WIDTH must be in 1..32");
    end

    state_t                            r_state;
    state_t                            w_next_state;
    logic [WINDOW_WIDTH-1:0]           r_window_cnt;
    logic                              w_restart;
    logic                              w_enter_measure;
    logic                              w_count_enable;
    logic                              w_commit;
    logic [CHANNELS*32-1:0]            r_target;
    logic [CHANNELS*32-1:0]            r_deviation;
    logic [CHANNELS*COUNTER_WIDTH-1:0] w_edge_count;
    logic [CHANNELS-1:0]               w_overflow;
    logic [CHANNELS*COUNTER_WIDTH-1:0] w_freq;
    logic [CHANNELS-1:0]               w_in_band;
    logic [CHANNELS*COUNTER_WIDTH-1:0] r_freq_value;
    logic [CHANNELS-1:0]               r_in_band;
    logic [CHANNELS-1:0]               r_overflow;
    logic                              r_freq_valid;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; clear outranks everything, enable low aborts a window
    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && enable) w_next_state = MEASURE;
                end
                MEASURE: begin
                    if (!enable)                         w_next_state = IDLE;
                    else if (r_window_cnt == WINDOW_LAST) w_next_state = LATCH;
                end
                LATCH: begin
                    if (enable && continuous) w_next_state = MEASURE;
                    else                      w_next_state = IDLE;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // State-derived controls: counting gate, window restart and result commit
    always_comb begin
        busy            = (r_state == MEASURE) || (r_state == LATCH);
        w_count_enable  = (r_state == MEASURE);
        w_enter_measure = (w_next_state == MEASURE) && (r_state != MEASURE);
        w_restart       = clear || w_enter_measure;
        w_commit        = (r_state == LATCH) && enable && !clear;
    end

    // Gate window counter, restarted on every MEASURE entry
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_window_cnt <= '0;
        end else if (w_restart) begin
            r_window_cnt <= '0;
        end else if (r_state == MEASURE) begin
            r_window_cnt <= r_window_cnt + 1'b1;
        end
    end

    // Capture targets and deviations at window start so mid-window edits
    // only affect the following window
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_target    <= '0;
            r_deviation <= '0;
        end else if (w_enter_measure) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_target[i*32 +: 32]    <= (target[i*32 +: 32] == VALUE_NOT_SET)
                                           ? 32'(DEFAULT_FREQUENCY) : target[i*32 +: 32];
                r_deviation[i*32 +: 32] <= (deviation[i*32 +: 32] == VALUE_NOT_SET)
                                           ? 32'(DEFAULT_DEVIATION) : deviation[i*32 +: 32];
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        frequency_channel_counter #(
            .COUNTER_WIDTH (COUNTER_WIDTH)
        ) u_counter (
            .clock        (clock),
            .reset        (reset),
            .sample_data  (sample_data[i]),
            .restart      (w_restart),
            .count_enable (w_count_enable),
            .edge_count   (w_edge_count[i*COUNTER_WIDTH +: COUNTER_WIDTH]),
            .overflow     (w_overflow[i])
        );

        // Scale edges to Hz (truncated to the result width) and compare
        assign w_freq[i*COUNTER_WIDTH +: COUNTER_WIDTH] =
            COUNTER_WIDTH'(64'(w_edge_count[i*COUNTER_WIDTH +: COUNTER_WIDTH]) * SCALE);
        assign w_in_band[i] = within_band(32'(w_freq[i*COUNTER_WIDTH +: COUNTER_WIDTH]),
                                          r_target[i*32 +: 32],
                                          r_deviation[i*32 +: 32]);
    end

    // Result registers: updated from the LATCH cycle, held otherwise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_freq_value <= '0;
            r_in_band    <= '0;
            r_overflow   <= '0;
            r_freq_valid <= 1'b0;
        end else if (clear) begin
            r_freq_value <= '0;
            r_in_band    <= '0;
            r_overflow   <= '0;
            r_freq_valid <= 1'b0;
        end else if (w_commit) begin
            r_freq_value <= w_freq;
            r_in_band    <= w_in_band;
            r_overflow   <= w_overflow;
            r_freq_valid <= 1'b1;
        end else begin
            r_freq_valid <= 1'b0;
        end
    end

    assign freq_value = r_freq_value;
    assign in_band    = r_in_band;
    assign overflow   = r_overflow;
    assign freq_valid = r_freq_valid;

endmodule : multichannel_frequency_analyzer
`default_nettype wire

// File: doc/multichannel_frequency_analyzer.md
Name: multichannel_frequency_analyzer

Overview:
- N-channel successor to the two-tone frequency analyzer.
- Measures the rising-edge rate of CHANNELS independent 1-bit sample inputs over a programmable gate window and scales each count to Hz.
- Flags each channel as in-band against a per-channel target ± deviation, with default substitution when a runtime target/deviation is 0 (value-not-set).
- Sits between the raw demodulator bit inputs and the tone decoder; supports single-shot and continuous measurement.

Parameters:
CHANNELS, 2, number of independent sample inputs (1..16)
CLOCK_FREQUENCY, 50000000, clock rate in Hz
WINDOW_CYCLES, 50000000, gate window length in clocks; CLOCK_FREQUENCY must divide exactly, elaboration error otherwise
DEFAULT_FREQUENCY, 10000, target Hz used when a channel's target input is 0
DEFAULT_DEVIATION, 20, tolerance Hz used when a channel's deviation input is 0
COUNTER_WIDTH, 32, edge counter width and result width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  analyzer enable; low aborts the current window
clear  in  1  synchronous clear of counters, results and state
start  in  1  one-cycle pulse that starts a window from IDLE
continuous  in  1  1 = re-arm automatically after each window
sample_data  in  CHANNELS  asynchronous tone inputs
target  in  CHANNELS*32  per-channel target Hz, 0 = default
deviation  in  CHANNELS*32  per-channel tolerance Hz, 0 = default
freq_value  out  CHANNELS*COUNTER_WIDTH  measured Hz per channel
in_band  out  CHANNELS  |freq - target| <= deviation
overflow  out  CHANNELS  edge counter saturated during the window
freq_valid  out  1  one-cycle strobe when results update
busy  out  1  high in MEASURE and LATCH

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all counters, freq_value, in_band, overflow, freq_valid and busy are 0.
- Input path per channel:
  - 2-flop synchronizer, then a previous-value flop.
  - Rising-edge pulse occurs 3 clocks after the input transition.
  - Falling edges are ignored.
- States:
  - IDLE -> MEASURE on start=1 and enable=1.
  - MEASURE -> LATCH when window_cnt == WINDOW_CYCLES-1.
  - LATCH -> MEASURE if continuous=1 (sampled in LATCH), else -> IDLE.
- On MEASURE entry: window_cnt=0, edge counters=0, overflow accumulators=0. Targets and deviations are registered with default substitution; mid-window changes take effect next window.
- Window boundary: an edge in the final MEASURE cycle counts toward the ending window. The next window has no gap cycles except the single LATCH cycle; edges in LATCH are dropped.
- Edge counters saturate at all-ones and set that channel's overflow accumulator.
- LATCH computation:
  - freq = count * (CLOCK_FREQUENCY/WINDOW_CYCLES), truncated to COUNTER_WIDTH.
  - in_band uses a 33-bit signed difference against the registered target and deviation.
  - freq_value, in_band and overflow register on the clock after LATCH.
  - freq_valid pulses exactly that cycle.
- Results hold until the next valid strobe or clear.
- enable=0 in MEASURE or LATCH: go to IDLE next clock, discard the window, no freq_valid, previous results retained.
- clear=1: takes priority over start and enable. Next clock: IDLE, results and counters 0, freq_valid 0.
- start while busy is ignored. start and clear in the same cycle: clear wins.
- Reset mid-window: immediate return to reset values.

Decomposition:
- Package frequency_analyzer_pkg holds:
  - state enum (IDLE, MEASURE, LATCH);
  - VALUE_NOT_SET=0;
  - SCALE = CLOCK_FREQUENCY/WINDOW_CYCLES function;
  - in-band compare function.
- Sub-module frequency_channel_counter (synchronizer, edge detect, saturating counter, overflow) is instantiated CHANNELS times via generate.
- The top level holds the FSM, window counter, scaling and compare.

Test Plan:
- Bench parameters for all scenarios: CLOCK_FREQUENCY=1000000, WINDOW_CYCLES=1000 (scale 1000 Hz).
- ch0 square wave with period 100 clocks, ch1 period 125, targets 0, deviations 0, single-shot start -> one freq_valid ~1002 clocks later; freq_value ch0=10000, ch1=8000; in_band=2'b01; overflow=0; busy falls.
- continuous=1, same inputs -> freq_valid every 1001 clocks with identical values. Drop continuous -> exactly one more strobe, then IDLE.
- target ch1=8000, deviation ch1=500, ch1 period 125 -> in_band=2'b11. Then target ch1=9000 mid-window -> that window still 2'b11, next window 2'b01.
- enable deasserted at clock 500 of a window -> no freq_valid, results unchanged from the prior window, state IDLE. clear together with start -> outputs 0, stays IDLE.
- Bench override COUNTER_WIDTH=4, ch0 period 20 (50 edges) -> count saturates at 15, overflow[0]=1, freq_value truncated value checked against the model.
- reset asserted at clock 300 of a window with continuous=1 -> all outputs 0 immediately. After release, start required to resume.
